// File: rtl/sonic_array.sv
// Round-robin ultrasonic ranging controller: one echo measurement slot per channel,
// width-to-centimetre conversion and per-channel result registers.
module sonic_array #(
    parameter int CH      = 4,
    parameter int DW      = 9,
    parameter int SLOT    = 60000,
    parameter int TRIG_W  = 10,
    parameter int TMO     = 30000,
    parameter int NEAR_CM = 10
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    en,
    input  logic [CH-1:0]                           echo,
    output logic [CH-1:0]                           trig,
    output logic [CH*DW-1:0]                        distance,
    output logic [CH-1:0]                           valid,
    output logic [CH-1:0]                           tmo_flag,
    output logic [CH-1:0]                           near,
    output logic                                    upd,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0]  upd_ch
);

    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int SW = $clog2(SLOT);
    localparam logic [SW-1:0] CNT_LAST = SW'(SLOT - 1);
    localparam logic [SW-1:0] CNT_TMO  = SW'(TMO);
    localparam logic [SW-1:0] CNT_TRIG = SW'(TRIG_W);
    localparam logic [15:0]   W_MAX    = 16'(TMO);
    localparam logic [31:0]   D_MAX    = 32'((1 << DW) - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(CH - 1);

    // ARM: wait for echo low | WAIT_HI: wait for rise | MEAS: count width | DONE: hold until slot end
    typedef enum logic [1:0] {ARM, WAIT_HI, MEAS, DONE} state_t;

    state_t           state_q;
    logic [CH-1:0]    echo_s1_q, echo_s2_q, echo_d_q;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    cur_q, cur_d, cur_adv;
    logic             run_q, run_d;
    logic             pend_q, pend_d;
    logic             timed_q;
    logic [15:0]      wid_q, wid_inc, meas_q;
    logic [CH-1:0]    trig_q, trig_d;
    logic [CH*DW-1:0] dist_q;
    logic [CH-1:0]    valid_q, tmo_q, near_q;
    logic             upd_q;
    logic [CW-1:0]    upd_ch_q;
    logic             e_cur, rise, fall, slot_end;
    logic [31:0]      prod, quo;
    logic [DW-1:0]    dist_new;

    always_comb begin
        e_cur    = echo_s2_q[cur_q];
        rise     = e_cur & ~echo_d_q[cur_q];
        fall     = ~e_cur & echo_d_q[cur_q];
        slot_end = run_q && (cnt_q == CNT_LAST);
        cur_adv  = (cur_q == CH_LAST) ? '0 : cur_q + CW'(1);
        wid_inc  = (wid_q >= W_MAX) ? W_MAX : wid_q + 16'd1;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        run_d    = run_q;
        pend_d   = pend_q;
        // A slot finished while disabled leaves the channel advance pending until en returns.
        if (slot_end) begin
            cnt_d = '0;
            if (en) begin
                cur_d = cur_adv;
            end else begin
                run_d  = 1'b0;
                pend_d = 1'b1;
            end
        end else if (run_q) begin
            cnt_d = cnt_q + SW'(1);
        end else if (en) begin
            run_d  = 1'b1;
            pend_d = 1'b0;
            if (pend_q) cur_d = cur_adv;
        end
        trig_d = '0;
        if (run_d && (cnt_d < CNT_TRIG)) trig_d[cur_d] = 1'b1;
        prod     = 32'(meas_q) * 32'd17;
        quo      = prod / 32'd1000;
        dist_new = (quo > D_MAX) ? DW'(D_MAX) : DW'(quo);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARM;
            echo_s1_q <= '0;
            echo_s2_q <= '0;
            echo_d_q  <= '0;
            cnt_q     <= '0;
            cur_q     <= '0;
            run_q     <= 1'b0;
            pend_q    <= 1'b0;
            timed_q   <= 1'b0;
            wid_q     <= '0;
            meas_q    <= '0;
            trig_q    <= '0;
            dist_q    <= '0;
            valid_q   <= '0;
            tmo_q     <= '0;
            near_q    <= '0;
            upd_q     <= 1'b0;
            upd_ch_q  <= '0;
        end else begin
            echo_s1_q <= echo;
            echo_s2_q <= echo_s1_q;
            echo_d_q  <= echo_s2_q;
            cnt_q     <= cnt_d;
            cur_q     <= cur_d;
            run_q     <= run_d;
            pend_q    <= pend_d;
            trig_q    <= trig_d;
            upd_q     <= slot_end;
            upd_ch_q  <= slot_end ? cur_q : cur_d;
            if (slot_end) begin
                state_q <= ARM;
                timed_q <= 1'b0;
                if (state_q == DONE && !timed_q) begin
                    dist_q[int'(cur_q)*DW +: DW] <= dist_new;
                    valid_q[cur_q] <= 1'b1;
                    tmo_q[cur_q]   <= 1'b0;
                    near_q[cur_q]  <= 32'(dist_new) < 32'(NEAR_CM);
                end else begin
                    tmo_q[cur_q] <= 1'b1;
                end
            end else if (run_q) begin
                if (state_q != DONE && cnt_q == CNT_TMO) begin
                    state_q <= DONE;
                    timed_q <= 1'b1;
                end else begin
                    case (state_q)
                        ARM:     if (!e_cur) state_q <= WAIT_HI;
                        WAIT_HI: if (rise) begin
                            state_q <= MEAS;
                            wid_q   <= '0;
                        end
                        MEAS: begin
                            if (fall) begin
                                state_q <= DONE;
                                meas_q  <= wid_inc;
                            end else begin
                                wid_q <= wid_inc;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign trig     = trig_q;
    assign distance = dist_q;
    assign valid    = valid_q;
    assign tmo_flag = tmo_q;
    assign near     = near_q;
    assign upd      = upd_q;
    assign upd_ch   = upd_ch_q;

endmodule

// File: tb/tb_sonic_array.sv
// Bench for sonic_array: a slot-level scoreboard checked every cycle on a 4-channel
// instance, plus literal checks on a 6-bit-distance instance for saturation and timeouts.
module tb_sonic_array;

    localparam int CH = 4, DW = 9, SLOT = 2500, TRIG_W = 10, TMO = 2200, NEAR = 10;
    localparam int DW2 = 6, SLOT2 = 6000, TMO2 = 5500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, en;
    logic [CH-1:0]    echo, trig, valid, tmo_flag, near;
    logic [CH*DW-1:0] distance;
    logic             upd;
    logic [1:0]       upd_ch;

    logic             rst2, en2;
    logic [1:0]       echo2, trig2, valid2, tmo2, near2;
    logic [2*DW2-1:0] distance2;
    logic             upd2;
    logic [0:0]       upd_ch2;

    sonic_array #(.CH(CH), .DW(DW), .SLOT(SLOT), .TRIG_W(TRIG_W), .TMO(TMO), .NEAR_CM(NEAR)) dut (
        .clk(clk), .rst(rst), .en(en), .echo(echo), .trig(trig), .distance(distance),
        .valid(valid), .tmo_flag(tmo_flag), .near(near), .upd(upd), .upd_ch(upd_ch));

    sonic_array #(.CH(2), .DW(DW2), .SLOT(SLOT2), .TRIG_W(TRIG_W), .TMO(TMO2), .NEAR_CM(NEAR)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .echo(echo2), .trig(trig2), .distance(distance2),
        .valid(valid2), .tmo_flag(tmo2), .near(near2), .upd(upd2), .upd_ch(upd_ch2));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_fail = 0;
    bit chk_on = 1'b0;
    bit done2 = 1'b0;
    int s2_start = 0;
    int plan_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse(input int ch, input int t, input int w);
        wait_to(t);
        echo[ch] = 1'b1;
        wait_to(t + w);
        echo[ch] = 1'b0;
    endtask

    // Slot-level model: slots last SLOT cycles from their start edge, results come from plan_q.
    int m_dist[CH];
    bit m_valid[CH], m_tmo[CH], m_near[CH];
    bit m_active = 1'b0;
    int m_start = 0, m_ch = 0, m_next = 0;
    logic [CH-1:0]    e_trig, e_valid, e_tmo, e_near;
    logic [CH*DW-1:0] e_dist;
    logic             e_upd;
    int               e_uch, w, d;

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            e_upd = 1'b0;
            if (rst) begin
                for (int i = 0; i < CH; i++) begin
                    m_dist[i] = 0; m_valid[i] = 0; m_tmo[i] = 0; m_near[i] = 0;
                end
                m_active = 1'b0; m_ch = 0; m_next = 0;
                e_uch = 0;
            end else begin
                e_uch = m_ch;
                if (m_active && cyc == m_start + SLOT) begin
                    e_upd = 1'b1;
                    e_uch = m_ch;
                    if (plan_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL plan_underflow: commit on ch %0d with no planned result at cycle %0d", m_ch, cyc);
                    end else begin
                        w = plan_q.pop_front();
                        if (w < 0) begin
                            m_tmo[m_ch] = 1'b1;
                        end else begin
                            d = (w * 17) / 1000;
                            if (d > (1 << DW) - 1) d = (1 << DW) - 1;
                            m_dist[m_ch] = d; m_valid[m_ch] = 1'b1; m_tmo[m_ch] = 1'b0;
                            m_near[m_ch] = (d < NEAR);
                        end
                    end
                    m_next = (m_ch + 1) % CH;
                    m_active = 1'b0;
                end
                if (!m_active && en) begin
                    m_active = 1'b1; m_start = cyc; m_ch = m_next;
                    if (!e_upd) e_uch = m_ch;
                end
            end
            e_trig = '0;
            if (!rst && m_active && (cyc - m_start) < TRIG_W) e_trig[m_ch] = 1'b1;
            for (int i = 0; i < CH; i++) begin
                e_dist[i*DW +: DW] = DW'(m_dist[i]);
                e_valid[i] = m_valid[i]; e_tmo[i] = m_tmo[i]; e_near[i] = m_near[i];
            end
            chk("model_trig", trig, e_trig);
            chk("model_distance", distance, e_dist);
            chk("model_valid", valid, e_valid);
            chk("model_tmo_flag", tmo_flag, e_tmo);
            chk("model_near", near, e_near);
            chk("model_upd", upd, e_upd);
            chk("model_upd_ch", upd_ch, e_uch);
        end
    end

    initial begin
        int s0, s1, s2, s3, s4, s5, s6, s7, s8;
        rst = 1'b1; en = 1'b1; echo = '0;
        rst2 = 1'b1; en2 = 1'b1; echo2 = '0;
        chk_on = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_trig", trig, 0);
        chk("reset_distance", distance, 0);
        chk("reset_upd_ch", upd_ch, 0);
        s2_start = cyc + 1;
        rst = 1'b0; rst2 = 1'b0;
        s0 = cyc + 1;

        plan_q.push_back(1000);
        pulse(0, s0 + 20, 1000);
        wait_to(s0 + SLOT);
        chk("ch0_distance", distance[0*DW +: DW], 17);
        chk("ch0_valid", valid[0], 1);
        chk("ch0_near", near[0], 0);
        chk("ch0_upd", upd, 1);
        chk("ch0_upd_ch", upd_ch, 0);

        s1 = s0 + SLOT;
        plan_q.push_back(500);
        wait_to(s1 + 9);
        chk("ch1_trig_last_high", trig, 4'b0010);
        wait_to(s1 + 10);
        chk("ch1_trig_low", trig, 0);
        pulse(1, s1 + 20, 500);
        wait_to(s1 + SLOT);
        chk("ch1_distance", distance[1*DW +: DW], 8);
        chk("ch1_near", near[1], 1);

        s2 = s1 + SLOT;
        plan_q.push_back(-1);
        wait_to(s2 + SLOT);
        chk("ch2_tmo_flag", tmo_flag[2], 1);
        chk("ch2_valid", valid[2], 0);
        chk("ch2_distance", distance[2*DW +: DW], 0);

        s3 = s2 + SLOT;
        plan_q.push_back(1);
        pulse(3, s3 + 20, 1);
        wait_to(s3 + SLOT);
        chk("ch3_width1_distance", distance[3*DW +: DW], 0);
        chk("ch3_width1_valid", valid[3], 1);

        s4 = s3 + SLOT;
        s5 = s4 + SLOT;
        plan_q.push_back(100);
        plan_q.push_back(200);
        pulse(1, s4 + 20, 50);
        pulse(0, s4 + 100, 100);
        pulse(0, s4 + 600, 300);
        pulse(1, s5 - 30, 130);
        chk("ch0_ignore_late_echo", distance[0*DW +: DW], 1);
        pulse(1, s5 + 300, 200);
        wait_to(s5 + SLOT);
        chk("ch1_high_at_start", distance[1*DW +: DW], 3);

        s6 = s5 + SLOT;
        plan_q.push_back(2000);
        wait_to(s6 + 20);
        echo[2] = 1'b1;
        wait_to(s6 + 1000);
        en = 1'b0;
        wait_to(s6 + 2020);
        echo[2] = 1'b0;
        wait_to(s6 + SLOT);
        chk("ch2_recover_distance", distance[2*DW +: DW], 34);
        chk("ch2_recover_tmo_flag", tmo_flag[2], 0);
        wait_to(s6 + SLOT + 200);
        chk("idle_trig", trig, 0);
        chk("idle_upd_ch", upd_ch, 2);
        en = 1'b1;
        s7 = cyc + 1;

        wait_to(s7 + 20);
        echo[3] = 1'b1;
        wait_to(s7 + 500);
        rst = 1'b1;
        #1;
        chk("rst_mid_trig", trig, 0);
        chk("rst_mid_distance", distance, 0);
        chk("rst_mid_flags", {valid, tmo_flag, near, upd}, 0);
        wait_to(s7 + 503);
        echo[3] = 1'b0;
        rst = 1'b0;
        s8 = cyc + 1;
        plan_q.push_back(1000);
        wait_to(s8 + 5);
        chk("post_rst_trig_ch0", trig, 4'b0001);
        pulse(0, s8 + 20, 1000);
        wait_to(s8 + SLOT);
        chk("post_rst_distance", distance[0*DW +: DW], 17);
        chk("post_rst_upd_ch", upd_ch, 0);
        chk("post_rst_ch3_valid", valid[3], 0);
        wait_to(s8 + SLOT + 5);

        for (int i = 0; i < 20000 && !done2; i++) @(negedge clk);
        chk("dut2_finished", done2, 1);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int b;
        wait (rst2 === 1'b0);
        b = s2_start;
        wait_to(b + 20);
        echo2[0] = 1'b1;
        wait_to(b + 5020);
        echo2[0] = 1'b0;
        wait_to(b + SLOT2);
        chk("dw6_sat_distance", distance2[0 +: DW2], 63);
        chk("dw6_sat_valid", valid2[0], 1);
        chk("dw6_sat_near", near2[0], 0);
        chk("dw6_sat_upd", {upd2, upd_ch2}, 2'b10);
        wait_to(b + 2*SLOT2 - 50);
        echo2[0] = 1'b1;
        wait_to(b + 2*SLOT2);
        chk("dw6_ch1_tmo", {tmo2[1], valid2[1]}, 2'b10);
        chk("dw6_ch1_upd_ch", upd_ch2, 1);
        wait_to(b + 2*SLOT2 + 2950);
        echo2[0] = 1'b0;
        wait_to(b + 3*SLOT2);
        chk("dw6_held_distance", distance2[0 +: DW2], 63);
        chk("dw6_held_tmo_valid", {tmo2[0], valid2[0]}, 2'b11);
        chk("dw6_held_upd", {upd2, upd_ch2}, 2'b10);
        done2 = 1'b1;
    end

endmodule
